// File: rtl/mouv_analyse_axil_regs.sv
// rtl/mouv_analyse_axil_regs.sv - AXI4-Lite slave register file for the MouvAnalyseIP core.
// Optional: MOUVANALYSE_AXIL_SLVERR_EN makes out-of-range accesses answer SLVERR.
module mouv_analyse_axil_regs #(
    parameter int ADDR_WIDTH = 6,
    parameter int NUM_REGS   = 4
) (
    input  logic                     ACLK,
    input  logic                     ARESET,
    input  logic [ADDR_WIDTH-1:0]    AWADDR,
    input  logic [2:0]               AWPROT,
    input  logic                     AWVALID,
    output logic                     AWREADY,
    input  logic [31:0]              WDATA,
    input  logic [3:0]               WSTRB,
    input  logic                     WVALID,
    output logic                     WREADY,
    output logic [1:0]               BRESP,
    output logic                     BVALID,
    input  logic                     BREADY,
    input  logic [ADDR_WIDTH-1:0]    ARADDR,
    input  logic [2:0]               ARPROT,
    input  logic                     ARVALID,
    output logic                     ARREADY,
    output logic [31:0]              RDATA,
    output logic [1:0]               RRESP,
    output logic                     RVALID,
    input  logic                     RREADY,
    output logic [32*NUM_REGS-1:0]   regs_o
);

    localparam int IDX_W = ADDR_WIDTH - 2;
    localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef MOUVANALYSE_AXIL_SLVERR_EN
    localparam logic [1:0] RESP_OOR = 2'b10;
`else
    localparam logic [1:0] RESP_OOR = 2'b00;
`endif

    typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ACK, R_DATA} r_state_t;

    w_state_t                  w_state;
    r_state_t                  r_state;
    logic [32*NUM_REGS-1:0]    regs_q;
    logic [IDX_W-1:0]          w_idx;
    logic [IDX_W-1:0]          r_idx;
    logic                      w_in_range;
    logic                      r_in_range;
    logic [31:0]               rd_word;
    logic                      unused_bits;

    assign w_idx      = AWADDR[ADDR_WIDTH-1:2];
    assign r_idx      = ARADDR[ADDR_WIDTH-1:2];
    assign w_in_range = int'(w_idx) < NUM_REGS;
    assign r_in_range = int'(r_idx) < NUM_REGS;
    assign regs_o     = regs_q;
    assign unused_bits = ^{AWPROT, ARPROT, AWADDR[1:0], ARADDR[1:0]};

    // Out-of-range indices match no register and so read back as zero.
    always_comb begin
        rd_word = 32'h0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (r_idx == IDX_W'(k)) begin
                rd_word = regs_q[32*k +: 32];
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_state <= W_IDLE;
            AWREADY <= 1'b0;
            WREADY  <= 1'b0;
            BVALID  <= 1'b0;
            BRESP   <= 2'b00;
            regs_q  <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    // Address and data are only taken together.
                    if (AWVALID && WVALID) begin
                        AWREADY <= 1'b1;
                        WREADY  <= 1'b1;
                        w_state <= W_ACK;
                    end
                end
                W_ACK: begin
                    AWREADY <= 1'b0;
                    WREADY  <= 1'b0;
                    for (int k = 0; k < NUM_REGS; k++) begin
                        if (w_idx == IDX_W'(k)) begin
                            for (int b = 0; b < 4; b++) begin
                                if (WSTRB[b]) begin
                                    regs_q[32*k + 8*b +: 8] <= WDATA[8*b +: 8];
                                end
                            end
                        end
                    end
                    BRESP   <= w_in_range ? RESP_OKAY : RESP_OOR;
                    BVALID  <= 1'b1;
                    w_state <= W_RESP;
                end
                W_RESP: begin
                    if (BREADY) begin
                        BVALID  <= 1'b0;
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Capture reads the pre-edge register value, so a same-edge write returns old data.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state <= R_IDLE;
            ARREADY <= 1'b0;
            RVALID  <= 1'b0;
            RDATA   <= 32'h0;
            RRESP   <= 2'b00;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ARVALID) begin
                        ARREADY <= 1'b1;
                        r_state <= R_ACK;
                    end
                end
                R_ACK: begin
                    ARREADY <= 1'b0;
                    RDATA   <= rd_word;
                    RRESP   <= r_in_range ? RESP_OKAY : RESP_OOR;
                    RVALID  <= 1'b1;
                    r_state <= R_DATA;
                end
                R_DATA: begin
                    if (RREADY) begin
                        RVALID  <= 1'b0;
                        r_state <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mouv_analyse_axil_regs.sv
// tb/tb_mouv_analyse_axil_regs.sv - self-checking bench for mouv_analyse_axil_regs.
module tb_mouv_analyse_axil_regs;

    localparam int AW = 6;
    localparam int NR = 4;
`ifdef MOUVANALYSE_AXIL_SLVERR_EN
    localparam logic [1:0] EXP_OOR = 2'b10;
`else
    localparam logic [1:0] EXP_OOR = 2'b00;
`endif

    logic ACLK = 1'b0;
    logic ARESET;
    logic [AW-1:0] AWADDR, ARADDR;
    logic [2:0] AWPROT, ARPROT;
    logic AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic ARVALID, ARREADY, RVALID, RREADY;
    logic [31:0] WDATA, RDATA;
    logic [3:0] WSTRB;
    logic [1:0] BRESP, RRESP;
    logic [32*NR-1:0] regs_o;

    int checks = 0;
    int failures = 0;
    logic [31:0] model [NR];

    always #5 ACLK = ~ACLK;

    mouv_analyse_axil_regs #(.ADDR_WIDTH(AW), .NUM_REGS(NR)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .regs_o(regs_o)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] model_flat();
        logic [127:0] f = '0;
        for (int k = 0; k < NR; k++) f[32*k +: 32] = model[k];
        return f;
    endfunction

    function automatic void model_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
        int idx = int'(a) / 4;
        if (idx < NR)
            for (int b = 0; b < 4; b++)
                if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
    endfunction

    function automatic logic [31:0] model_read(input logic [AW-1:0] a);
        int idx = int'(a) / 4;
        return (idx < NR) ? model[idx] : 32'h0;
    endfunction

    function automatic logic [1:0] model_resp(input logic [AW-1:0] a);
        return (int'(a) / 4 < NR) ? 2'b00 : EXP_OOR;
    endfunction

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp);
        int n = 0;
        AWADDR = a; WDATA = d; WSTRB = s; AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
        do begin tick(); n++; end while (!(AWREADY && WREADY) && n < 20);
        if (n >= 20) check("write_handshake_timeout", 0, 1);
        tick();
        AWVALID = 1'b0; WVALID = 1'b0;
        n = 0;
        while (!BVALID && n < 20) begin tick(); n++; end
        if (n >= 20) check("bvalid_timeout", 0, 1);
        resp = BRESP;
        tick();
    endtask

    task automatic do_read(input logic [AW-1:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n = 0;
        ARADDR = a; ARVALID = 1'b1; RREADY = 1'b1;
        do begin tick(); n++; end while (!ARREADY && n < 20);
        if (n >= 20) check("read_handshake_timeout", 0, 1);
        tick();
        ARVALID = 1'b0;
        n = 0;
        while (!RVALID && n < 20) begin tick(); n++; end
        if (n >= 20) check("rvalid_timeout", 0, 1);
        d = RDATA; resp = RRESP;
        tick();
    endtask

    typedef struct {
        logic            is_read;
        logic [AW-1:0]   addr;
        logic [31:0]     data;
        logic [3:0]      strb;
        logic [31:0]     exp_data;
        logic [1:0]      exp_resp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic [AW-1:0] a, input logic [31:0] d,
                                input logic [3:0] s, input logic [31:0] ed, input logic [1:0] er);
        vec_t v;
        v.is_read = r; v.addr = a; v.data = d; v.strb = s; v.exp_data = ed; v.exp_resp = er;
        return v;
    endfunction

    initial begin
        logic [31:0] rd;
        logic [1:0]  rs;
        logic [AW-1:0] ra;
        logic [31:0] rdat;
        logic [3:0]  rstb;

        ARESET = 1'b1; AWADDR = '0; ARADDR = '0; AWPROT = '0; ARPROT = '0;
        AWVALID = 0; WVALID = 0; BREADY = 0; ARVALID = 0; RREADY = 0; WDATA = '0; WSTRB = '0;
        for (int k = 0; k < NR; k++) model[k] = 32'h0;
        repeat (3) tick();
        check("reset_outputs", {AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RRESP, RDATA}, '0);
        check("reset_regs", regs_o, '0);
        ARESET = 1'b0;
        tick();

        vecs.push_back(mk(0, 6'h00, 32'h1, 4'hF, 0, 2'b00));
        vecs.push_back(mk(0, 6'h04, 32'h2, 4'hF, 0, 2'b00));
        vecs.push_back(mk(0, 6'h08, 32'h3, 4'hF, 0, 2'b00));
        vecs.push_back(mk(0, 6'h0C, 32'h4, 4'hF, 0, 2'b00));
        vecs.push_back(mk(1, 6'h00, 0, 0, 32'h1, 2'b00));
        vecs.push_back(mk(1, 6'h04, 0, 0, 32'h2, 2'b00));
        vecs.push_back(mk(1, 6'h0B, 0, 0, 32'h3, 2'b00));
        vecs.push_back(mk(1, 6'h0C, 0, 0, 32'h4, 2'b00));
        vecs.push_back(mk(0, 6'h00, 32'hAABBCCDD, 4'b0101, 0, 2'b00));
        vecs.push_back(mk(1, 6'h00, 0, 0, 32'h00BB00DD, 2'b00));
        vecs.push_back(mk(0, 6'h10, 32'hDEADBEEF, 4'hF, 0, EXP_OOR));
        vecs.push_back(mk(1, 6'h10, 0, 0, 32'h0, EXP_OOR));
        vecs.push_back(mk(0, 6'h04, 32'hFFFFFFFF, 4'b0000, 0, 2'b00));
        vecs.push_back(mk(1, 6'h05, 0, 0, 32'h2, 2'b00));
        vecs.push_back(mk(1, 6'h3C, 0, 0, 32'h0, EXP_OOR));

        foreach (vecs[i]) begin
            if (vecs[i].is_read) begin
                do_read(vecs[i].addr, rd, rs);
                check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_data);
                check($sformatf("vec%0d_rresp", i), rs, vecs[i].exp_resp);
            end else begin
                do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, rs);
                model_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
                check($sformatf("vec%0d_bresp", i), rs, vecs[i].exp_resp);
            end
            if (i == 3) check("regs_after_fill", regs_o, 128'h00000004_00000003_00000002_00000001);
        end
        check("regs_after_table", regs_o, 128'h00000004_00000003_00000002_00BB00DD);

        // AWVALID alone must not be accepted; BVALID/BRESP hold under backpressure.
        AWADDR = 6'h0C; WDATA = 32'h44; WSTRB = 4'hF; AWVALID = 1'b1; BREADY = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            check($sformatf("lone_aw_awready_c%0d", c), AWREADY, 0);
        end
        WVALID = 1'b1;
        tick();
        check("aw_w_ready_pulse", {AWREADY, WREADY}, 2'b11);
        tick();
        AWVALID = 1'b0; WVALID = 1'b0;
        model_write(6'h0C, 32'h44, 4'hF);
        check("ready_dropped", {AWREADY, WREADY}, 2'b00);
        check("reg_updated_at_bvalid", regs_o, model_flat());
        for (int c = 0; c < 4; c++) begin
            check($sformatf("bvalid_hold_c%0d", c), {BVALID, BRESP}, 3'b100);
            tick();
        end
        BREADY = 1'b1;
        tick();
        check("bvalid_released", BVALID, 0);

        // Read capture and write commit on the same edge for register 2.
        AWADDR = 6'h08; WDATA = 32'h9; WSTRB = 4'hF; ARADDR = 6'h08;
        AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1; BREADY = 1'b1; RREADY = 1'b1;
        tick();
        check("collision_readies", {AWREADY, ARREADY}, 2'b11);
        tick();
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        check("collision_valids", {BVALID, RVALID}, 2'b11);
        check("collision_old_data", RDATA, 32'h3);
        tick();
        model_write(6'h08, 32'h9, 4'hF);
        do_read(6'h08, rd, rs);
        check("collision_new_data", rd, 32'h9);

        // Reset while the write response is pending.
        AWADDR = 6'h00; WDATA = 32'h55; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b0;
        tick();
        tick();
        AWVALID = 1'b0; WVALID = 1'b0;
        check("pre_reset_bvalid", BVALID, 1);
        ARESET = 1'b1;
        tick();
        check("reset_drops_bvalid", BVALID, 0);
        check("reset_clears_regs", regs_o, '0);
        ARESET = 1'b0;
        for (int k = 0; k < NR; k++) model[k] = 32'h0;
        tick();
        do_write(6'h04, 32'h77, 4'hF, rs);
        model_write(6'h04, 32'h77, 4'hF);
        check("post_reset_bresp", rs, 2'b00);
        check("post_reset_regs", regs_o, model_flat());

        for (int t = 0; t < 200; t++) begin
            ra = AW'($urandom_range(0, 63));
            if ($urandom_range(0, 1) == 1) begin
                rdat = $urandom;
                rstb = 4'($urandom_range(0, 15));
                do_write(ra, rdat, rstb, rs);
                check($sformatf("rand%0d_bresp", t), rs, model_resp(ra));
                model_write(ra, rdat, rstb);
            end else begin
                do_read(ra, rd, rs);
                check($sformatf("rand%0d_rdata", t), rd, model_read(ra));
                check($sformatf("rand%0d_rresp", t), rs, model_resp(ra));
            end
        end
        check("final_regs", regs_o, model_flat());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
